// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle LEGv8 control unit: FETCH/EXEC/MEM sequencing,
// instruction decode into a 30-bit datapath control word and a 64-bit immediate K.
module control_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in,
  input  logic [3:0]  status,
  input  logic [3:0]  flags,
  output logic [29:0] CtrlWord,
  output logic [63:0] K
);

  typedef enum logic [3:0] {ST_FETCH = 4'd0, ST_EXEC = 4'd1, ST_MEM = 4'd2} state_e;
  typedef enum logic [3:0] {
    C_NOP, C_R, C_SHIFT, C_I, C_MOVZ, C_LDUR, C_STUR,
    C_B, C_BL, C_BR, C_CBZ, C_CBNZ, C_BCOND
  } cls_e;

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  cls_e        cls;
  logic [4:0]  alu_fs;
  logic        set_fl;
  logic [4:0]  sa, sb, da, fs;
  logic        rw, bsel, mw, irl, sf, mr;
  logic [1:0]  dsel, pcsel;
  logic [3:0]  EXState;
  logic        fetch;
  logic        unused;

  function automatic logic cond_hold(input logic [3:0] c, input logic [3:0] f);
    logic r;
    case (c[3:1])
      3'd0:    r = f[0];
      3'd1:    r = f[2];
      3'd2:    r = f[1];
      3'd3:    r = f[3];
      3'd4:    r = f[2] & ~f[0];
      3'd5:    r = (f[1] == f[3]);
      3'd6:    r = ~f[0] & (f[1] == f[3]);
      default: r = 1'b1;
    endcase
    // Odd codes invert their pair, except 15 which is "always" like 14.
    return (c[0] && c[3:1] != 3'd7) ? ~r : r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    cls    = C_NOP;
    alu_fs = 5'd0;
    set_fl = 1'b0;
    if (ir_q[31:26] == 6'b000101)      cls = C_B;
    else if (ir_q[31:26] == 6'b100101) cls = C_BL;
    else if (ir_q[31:24] == 8'hB4)     cls = C_CBZ;
    else if (ir_q[31:24] == 8'hB5)     cls = C_CBNZ;
    else if (ir_q[31:24] == 8'h54)     cls = C_BCOND;
    else if (ir_q[31:23] == 9'h1A5)    cls = C_MOVZ;
    else begin
      case (ir_q[31:22])
        10'h244: cls = C_I;
        10'h2C4: begin cls = C_I; set_fl = 1'b1; end
        10'h344: begin cls = C_I; alu_fs = 5'd1; end
        10'h3C4: begin cls = C_I; alu_fs = 5'd1; set_fl = 1'b1; end
        10'h248: begin cls = C_I; alu_fs = 5'd2; end
        10'h3C8: begin cls = C_I; alu_fs = 5'd2; set_fl = 1'b1; end
        10'h2C8: begin cls = C_I; alu_fs = 5'd3; end
        10'h348: begin cls = C_I; alu_fs = 5'd4; end
        default: begin
          case (ir_q[31:21])
            11'h458: cls = C_R;
            11'h558: begin cls = C_R; set_fl = 1'b1; end
            11'h658: begin cls = C_R; alu_fs = 5'd1; end
            11'h758: begin cls = C_R; alu_fs = 5'd1; set_fl = 1'b1; end
            11'h450: begin cls = C_R; alu_fs = 5'd2; end
            11'h750: begin cls = C_R; alu_fs = 5'd2; set_fl = 1'b1; end
            11'h550: begin cls = C_R; alu_fs = 5'd3; end
            11'h650: begin cls = C_R; alu_fs = 5'd4; end
            11'h69B: begin cls = C_SHIFT; alu_fs = 5'd5; end
            11'h69A: begin cls = C_SHIFT; alu_fs = 5'd6; end
            11'h6B0: cls = C_BR;
            11'h7C2: cls = C_LDUR;
            11'h7C0: cls = C_STUR;
            default: cls = C_NOP;
          endcase
        end
      endcase
    end
  end

  always_comb begin
    K = 64'd0;
    case (cls)
      C_SHIFT:          K = {58'd0, ir_q[15:10]};
      C_I:              K = {52'd0, ir_q[21:10]};
      C_MOVZ:           K = {48'd0, ir_q[20:5]} << {ir_q[22:21], 4'd0};
      C_LDUR, C_STUR:   K = {{55{ir_q[20]}}, ir_q[20:12]};
      C_B, C_BL:        K = {{36{ir_q[25]}}, ir_q[25:0], 2'b00};
      C_CBZ, C_CBNZ,
      C_BCOND:          K = {{43{ir_q[23]}}, ir_q[23:5], 2'b00};
      default:          K = 64'd0;
    endcase
  end

  always_comb begin
    state_d = ST_FETCH;
    ir_d    = ir_q;
    sa = 5'd0; sb = 5'd0; da = 5'd0; fs = 5'd0;
    rw = 1'b0; bsel = 1'b0; mw = 1'b0; irl = 1'b0; sf = 1'b0; mr = 1'b0;
    dsel = 2'd0; pcsel = 2'd0;
    case (state_q)
      ST_FETCH: begin
        irl     = 1'b1;
        ir_d    = in;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = (cls == C_LDUR) ? ST_MEM : ST_FETCH;
        case (cls)
          C_R: begin
            sa = ir_q[9:5]; sb = ir_q[20:16]; da = ir_q[4:0];
            rw = 1'b1; fs = alu_fs; sf = set_fl; pcsel = 2'd1;
          end
          C_SHIFT, C_I: begin
            sa = ir_q[9:5]; da = ir_q[4:0]; rw = 1'b1; fs = alu_fs;
            sf = set_fl; bsel = 1'b1; pcsel = 2'd1;
          end
          C_MOVZ: begin
            sa = 5'd31; sb = 5'd31; da = ir_q[4:0]; rw = 1'b1;
            fs = 5'd7; bsel = 1'b1; pcsel = 2'd1;
          end
          // PC stays put here; the MEM cycle advances it after the load writes back.
          C_LDUR: begin sa = ir_q[9:5]; bsel = 1'b1; mr = 1'b1; end
          C_STUR: begin
            sa = ir_q[9:5]; sb = ir_q[4:0]; bsel = 1'b1; mw = 1'b1; pcsel = 2'd1;
          end
          C_B:  pcsel = 2'd2;
          C_BL: begin pcsel = 2'd2; rw = 1'b1; da = 5'd30; dsel = 2'd2; end
          C_BR: begin sa = ir_q[9:5]; pcsel = 2'd3; end
          C_CBZ, C_CBNZ: begin
            sb    = ir_q[4:0];
            fs    = 5'd7;
            pcsel = ((cls == C_CBZ) ~^ status[0]) ? 2'd2 : 2'd1;
          end
          C_BCOND: pcsel = cond_hold(ir_q[3:0], flags) ? 2'd2 : 2'd1;
          default: pcsel = 2'd1;
        endcase
      end
      ST_MEM: begin
        da = ir_q[4:0]; rw = 1'b1; dsel = 2'd1; mr = 1'b1; pcsel = 2'd1;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  assign CtrlWord = {mr, sf, irl, pcsel, dsel, mw, bsel, fs, rw, da, sb, sa};
  assign EXState  = state_q;
  assign fetch    = (state_q == ST_FETCH);
  assign unused   = ^{status[3:1], EXState, fetch};

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed and randomized bench for control_unit against
// a field-level instruction model.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in;
  logic [3:0]  status;
  logic [3:0]  flags;
  logic [29:0] CtrlWord;
  logic [63:0] K;

  control_unit dut (
    .clk(clk), .rst(rst), .in(in), .status(status), .flags(flags),
    .CtrlWord(CtrlWord), .K(K)
  );

  always #5 clk = ~clk;

  localparam logic [29:0] FETCH_W = 30'h0800_0000;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] prev_k;

  int r_opc[8] = '{32'h458, 32'h558, 32'h658, 32'h758, 32'h450, 32'h750, 32'h550, 32'h650};
  int r_fs[8]  = '{0, 0, 1, 1, 2, 2, 3, 4};
  int r_sf[8]  = '{0, 1, 0, 1, 0, 1, 0, 0};
  int i_opc[8] = '{32'h244, 32'h2C4, 32'h344, 32'h3C4, 32'h248, 32'h3C8, 32'h2C8, 32'h348};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [29:0] cw(int sa, int sb, int da, int rw, int fs, int bs,
                                     int mw, int ds, int pc, int sf, int mr);
    return 30'(sa + sb * 32 + da * 1024 + rw * (1 << 15) + fs * (1 << 16) + bs * (1 << 21)
               + mw * (1 << 22) + ds * (1 << 23) + pc * (1 << 25) + sf * (1 << 28)
               + mr * (1 << 29));
  endfunction

  function automatic bit cond_ok(int cond, logic [3:0] f);
    bit z, n, cy, v, base;
    z = f[0]; n = f[1]; cy = f[2]; v = f[3];
    case (cond / 2)
      0: base = z;
      1: base = cy;
      2: base = n;
      3: base = v;
      4: base = cy && !z;
      5: base = (n == v);
      6: base = !z && (n == v);
      default: return 1'b1;
    endcase
    return (cond % 2 == 1) ? !base : base;
  endfunction

  task automatic model(input int c, input logic [3:0] st, input logic [3:0] fl,
                       output logic [31:0] w, output logic [29:0] ex, output logic [63:0] k,
                       output bit ld, output logic [29:0] mem);
    int rd, rn, rm, sh, imm, hw, cond;
    longint s;
    rd = $urandom_range(0, 31); rn = $urandom_range(0, 31); rm = $urandom_range(0, 31);
    sh = $urandom_range(0, 63);
    ld = 1'b0; mem = '0; k = '0;
    if (c < 8) begin
      w  = (32'(r_opc[c]) << 21) | (32'(rm) << 16) | (32'(sh) << 10) | (32'(rn) << 5) | 32'(rd);
      ex = cw(rn, rm, rd, 1, r_fs[c], 0, 0, 0, 1, r_sf[c], 0);
    end else if (c < 10) begin
      w  = (32'(c == 8 ? 32'h69B : 32'h69A) << 21) | (32'(sh) << 10) | (32'(rn) << 5) | 32'(rd);
      ex = cw(rn, 0, rd, 1, (c == 8) ? 5 : 6, 1, 0, 0, 1, 0, 0);
      k  = 64'(sh);
    end else if (c < 18) begin
      imm = $urandom_range(0, 4095);
      w   = (32'(i_opc[c-10]) << 22) | (32'(imm) << 10) | (32'(rn) << 5) | 32'(rd);
      ex  = cw(rn, 0, rd, 1, r_fs[c-10], 1, 0, 0, 1, r_sf[c-10], 0);
      k   = 64'(imm);
    end else begin
      case (c)
        18: begin
          imm = $urandom_range(0, 65535); hw = $urandom_range(0, 3);
          w   = (32'h1A5 << 23) | (32'(hw) << 21) | (32'(imm) << 5) | 32'(rd);
          ex  = cw(31, 31, rd, 1, 7, 1, 0, 0, 1, 0, 0);
          k   = {48'd0, 16'(imm)} << (16 * hw);
        end
        19, 20: begin
          imm = $urandom_range(0, 511);
          w   = (32'(c == 19 ? 32'h7C2 : 32'h7C0) << 21) | (32'(imm) << 12)
              | (32'($urandom_range(0, 3)) << 10) | (32'(rn) << 5) | 32'(rd);
          s   = (imm >= 256) ? imm - 512 : imm;
          k   = 64'(s);
          if (c == 19) begin
            ex  = cw(rn, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
            ld  = 1'b1;
            mem = cw(0, 0, rd, 1, 0, 0, 0, 1, 1, 0, 1);
          end else begin
            ex = cw(rn, rd, 0, 0, 0, 1, 1, 0, 1, 0, 0);
          end
        end
        21, 22: begin
          imm = $urandom_range(0, (1 << 26) - 1);
          w   = (32'(c == 21 ? 5 : 37) << 26) | 32'(imm);
          s   = (imm >= (1 << 25)) ? imm - (1 << 26) : imm;
          k   = 64'(s * 4);
          ex  = (c == 21) ? cw(0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0)
                          : cw(0, 0, 30, 1, 0, 0, 0, 2, 2, 0, 0);
        end
        23: begin
          w  = (32'h6B0 << 21) | (32'(rn) << 5);
          ex = cw(rn, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0);
        end
        24, 25, 26: begin
          imm  = $urandom_range(0, (1 << 19) - 1);
          cond = $urandom_range(0, 15);
          s    = (imm >= (1 << 18)) ? imm - (1 << 19) : imm;
          k    = 64'(s * 4);
          if (c == 26) begin
            w  = (32'h54 << 24) | (32'(imm) << 5) | 32'(cond);
            ex = cw(0, 0, 0, 0, 0, 0, 0, 0, cond_ok(cond, fl) ? 2 : 1, 0, 0);
          end else begin
            w  = (32'(c == 24 ? 32'hB4 : 32'hB5) << 24) | (32'(imm) << 5) | 32'(rd);
            ex = cw(0, rd, 0, 0, 7, 0, 0, 0, ((c == 24) == st[0]) ? 2 : 1, 0, 0);
          end
        end
        default: begin
          w  = $urandom & 32'h03FF_FFFF;
          ex = cw(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        end
      endcase
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check({tag, "/r_state"}, {60'd0, dut.EXState}, 64'd0);
    check({tag, "/r_ctrl"}, {34'd0, CtrlWord}, {34'd0, FETCH_W});
    check({tag, "/r_k"}, K, 64'd0);
    prev_k = '0;
  endtask

  task automatic run(input string tag, input logic [31:0] w, input logic [29:0] ex,
                     input logic [63:0] k, input bit ld, input logic [29:0] mem,
                     input int rst_at);
    check({tag, "/f_state"}, {60'd0, dut.EXState}, 64'd0);
    check({tag, "/f_flag"}, {63'd0, dut.fetch}, 64'd1);
    check({tag, "/f_ctrl"}, {34'd0, CtrlWord}, {34'd0, FETCH_W});
    check({tag, "/f_k"}, K, prev_k);
    in = w;
    tick();
    check({tag, "/e_state"}, {60'd0, dut.EXState}, 64'd1);
    check({tag, "/e_flag"}, {63'd0, dut.fetch}, 64'd0);
    check({tag, "/e_ctrl"}, {34'd0, CtrlWord}, {34'd0, ex});
    check({tag, "/e_k"}, K, k);
    in = $urandom;
    #1;
    check({tag, "/e_hold"}, {34'd0, CtrlWord}, {34'd0, ex});
    if (rst_at == 1) begin
      do_reset(tag);
      return;
    end
    tick();
    if (ld) begin
      check({tag, "/m_state"}, {60'd0, dut.EXState}, 64'd2);
      check({tag, "/m_ctrl"}, {34'd0, CtrlWord}, {34'd0, mem});
      check({tag, "/m_k"}, K, k);
      if (rst_at == 2) begin
        do_reset(tag);
        return;
      end
      tick();
    end
    prev_k = k;
  endtask

  initial begin
    logic [31:0] w;
    logic [29:0] ex, mem;
    logic [63:0] k;
    bit          ld;
    int          c, ra;

    rst = 1'b1; in = $urandom; status = 4'd0; flags = 4'd0; prev_k = '0;
    tick();
    check("reset/state", {60'd0, dut.EXState}, 64'd0);
    check("reset/flag", {63'd0, dut.fetch}, 64'd1);
    check("reset/ctrl", {34'd0, CtrlWord}, 64'h0800_0000);
    check("reset/k", K, 64'd0);
    rst = 1'b0;

    run("movz", 32'hD280_00A2, 30'h0227_8BFF, 64'd5, 1'b0, 30'd0, 0);
    run("addi", 32'h9100_0843, 30'h0220_8C02, 64'd2, 1'b0, 30'd0, 0);
    run("ldur", 32'hF85F_8041, 30'h2020_0002, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 30'h2280_8400, 0);
    status = 4'b0001;
    run("cbz_taken", 32'hB400_0085, 30'h0407_00A0, 64'd16, 1'b0, 30'd0, 0);
    status = 4'b0000;
    run("cbz_fall", 32'hB400_0085, 30'h0207_00A0, 64'd16, 1'b0, 30'd0, 0);
    flags = 4'b0001;
    run("beq_taken", 32'h5400_0040, 30'h0400_0000, 64'd8, 1'b0, 30'd0, 0);
    flags = 4'b0000;
    run("beq_fall_rst", 32'h5400_0040, 30'h0200_0000, 64'd8, 1'b0, 30'd0, 1);
    run("ldur_rst_mem", 32'hF85F_8041, 30'h2020_0002, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1,
        30'h2280_8400, 2);

    for (int i = 0; i < 300; i++) begin
      c      = $urandom_range(0, 27);
      status = 4'($urandom);
      flags  = 4'($urandom);
      model(c, status, flags, w, ex, k, ld, mem);
      ra = 0;
      if ($urandom_range(0, 9) == 0) ra = ld ? $urandom_range(1, 2) : 1;
      run($sformatf("rand%0d_c%0d", i, c), w, ex, k, ld, mem, ra);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle control unit for the LEGv8 ("LEG") CPU.
- Each instruction runs FETCH, then EXEC, plus a MEM cycle for LDUR only.
- FETCH latches the instruction word into an internal IR.
- From the IR, the unit decodes a 30-bit datapath control word and a 64-bit immediate K; PC sequencing is driven through the control word.
- It sits between instruction memory, the register-file/ALU datapath and the flags register.

## Interface
No parameters.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous and active-high, sampled on the rising edge of clk.
- in  in  32  instruction word from instruction memory.
- status  in  4  live ALU status {V,C,N,Z} (bit0=Z, bit1=N, bit2=C, bit3=V).
- flags  in  4  stored flags register, same bit order.
- CtrlWord  out  30  datapath control word (fields below).
- K  out  64  immediate/offset constant.
- Internal probe points: `EXState` (4 bits: 0=FETCH, 1=EXEC, 2=MEM) and `fetch` (1 in FETCH).

## Operation
CtrlWord fields:
- [4:0] SA: read address A.
- [9:5] SB: read address B.
- [14:10] DA: write address.
- [15] RegWrite.
- [20:16] FS: ADD=0, SUB=1, AND=2, ORR=3, EOR=4, LSL=5, LSR=6, PASSB=7.
- [21] Bsel: 1 selects K as the ALU B input.
- [22] MemWrite.
- [24:23] DataSel: 0=ALU, 1=memory, 2=PC+4.
- [26:25] PCsel: 0=hold, 1=PC+4, 2=PC+K, 3=register A.
- [27] IRload.
- [28] SetFlags.
- [29] MemRead.

Field derivation:
- Unused fields are 0.
- SA=Rn[9:5], SB=Rm[20:16] for R-type, or Rt[4:0] for STUR/CBZ/CBNZ.
- DA=Rd[4:0]; BL writes DA=30.

Per-state words:
- FETCH: only IRload=1; PCsel=0. The IR captures `in` at the end of the cycle.
- EXEC, by instruction class:
  - R-type ADD/SUB/AND/ORR/EOR: RegWrite, FS per op, PCsel=1. ADDS/SUBS/ANDS additionally set SetFlags.
  - LSL/LSR: Bsel=1, K=shamt[15:10] zero-extended.
  - I-type ADDI/SUBI/ANDI/ORRI/EORI (and the S variants ADDIS/SUBIS/ANDIS): Bsel=1, K=imm12 zero-extended; the S variants also set SetFlags.
  - MOVZ (opcode[31:23]=110100101): SA=SB=31, FS=PASSB, Bsel=1, RegWrite, K=imm16<<(16*hw[22:21]).
  - LDUR: FS=ADD, Bsel=1, MemRead, K=sext(imm9[20:12]); go to MEM.
  - STUR: FS=ADD, Bsel=1, MemWrite, PCsel=1, same K.
  - B: PCsel=2, K=sext(imm26)<<2.
  - BL: as B, plus RegWrite, DA=30, DataSel=2.
  - BR: PCsel=3.
  - CBZ/CBNZ: FS=PASSB, K=sext(imm19[23:5])<<2. Take the branch (PCsel=2) when status.Z==1 for CBZ or 0 for CBNZ; otherwise PCsel=1.
  - B.cond: condition evaluated on `flags` using the standard cond[3:0] table (EQ, NE, HS, LO, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE; 14/15 = always). Taken → PCsel=2; not taken → PCsel=1.
  - Unrecognised opcode: all-zero word except PCsel=1 (NOP).
- MEM (LDUR only): RegWrite, DataSel=1, MemRead, PCsel=1, DA=Rt.
- K is combinational from the IR in every state; it is 0 for formats without an immediate.

## Timing
- State transitions, registered on the rising edge: FETCH→EXEC; EXEC→MEM if LDUR, else EXEC→FETCH; MEM→FETCH.
- Illegal EXState codes go to FETCH.
- Reset: EXState=FETCH and IR=0. CtrlWord then equals the FETCH word (only bit 27 set, value 0x08000000); K=0; fetch=1.
- Reset has priority at any state, including mid-LDUR.
- CtrlWord and K are combinational from EXState, IR, status and flags. No output latency beyond the state register.
- `in` is sampled only at the FETCH→EXEC edge; changes on `in` during EXEC or MEM are ignored.
- Latency: 2 cycles per instruction, 3 cycles for LDUR.

## Test plan
- Reset: assert rst for 1 edge → EXState=0, fetch=1, CtrlWord=0x08000000, K=0.
- MOVZ X2,#5: in=0xD28000A2, one fetch → EXEC word has DA=2, RegWrite=1, FS=7, Bsel=1, PCsel=1; K=5. The next edge returns to FETCH.
- ADDI X3,X2,#2: in=0x91000843 → EXEC has SA=2, DA=3, FS=0, Bsel=1, RegWrite=1; K=2. Changing `in` during EXEC leaves the word unchanged.
- LDUR X1,[X2,#-8]: in=0xF85F8041 → FETCH, EXEC (MemRead, K=0xFFFFFFFFFFFFFFF8), MEM (RegWrite, DataSel=1, DA=1), then FETCH.
- CBZ X5,+16: in=0xB4000085, with status.Z=1 → PCsel=2, K=16; with status.Z=0 → PCsel=1.
- B.EQ +8: in=0x54000040, with flags.Z=1 → PCsel=2; with flags=0 → PCsel=1. Assert rst during EXEC → next state FETCH.
